// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port: grants bursts of up to
// MAX_BURST beats to one requester at a time and gates pushes with fifo_full.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int W_DATA    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*W_DATA-1:0]   req_data,
   input  logic                      fifo_full,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          ack,
   output logic                      fifo_push,
   output logic [W_DATA-1:0]         fifo_data
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   win;
   logic               win_vld;
   logic               accept;
   logic               release_own;

   // Scan offsets from far to near so the set bit closest to ptr_q is written last and wins.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_w;
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_w = PTR_W'(idx);
         if (req[idx_w]) begin
            win     = idx_w;
            win_vld = 1'b1;
         end
      end
   end

   assign accept      = (state_q == BUSY) && req[owner_q] && !fifo_full;
   assign release_own = (state_q == BUSY) &&
                        (!req[owner_q] || (accept && (cnt_q == LAST_BEAT)));

   assign grant     = grant_q;
   assign fifo_push = accept;
   assign ack       = grant_q & {N_REQ{accept}};
   assign fifo_data = (state_q == BUSY) ? req_data[owner_q*W_DATA +: W_DATA] : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      if ((state_q == IDLE) || release_own) begin
         cnt_d = '0;
         if (win_vld) begin
            state_d = BUSY;
            owner_d = win;
            ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            grant_d = N_REQ'(1) << win;
         end else begin
            state_d = IDLE;
            grant_d = '0;
         end
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences and
// random traffic, all checked against a round-robin reference model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic           fifo_full;
   logic [N-1:0]   grant;
   logic [N-1:0]   ack;
   logic           fifo_push;
   logic [W-1:0]   fifo_data;

   fifo_wr_arbiter #(.N_REQ(N), .W_DATA(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .fifo_full (fifo_full),
      .grant     (grant),
      .ack       (ack),
      .fifo_push (fifo_push),
      .fifo_data (fifo_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: owner index (-1 = nobody), next-scan start, beats taken this grant.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_beats = 0;

   logic [3:0] obs_grant, obs_ack;
   logic       obs_push;
   logic [7:0] obs_data;

   logic [3:0] glog [32];
   logic       plog [32];
   logic [7:0] dlog [32];

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       full;
      logic [3:0] g;
      logic [3:0] a;
      logic       p;
      logic [7:0] d;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] mk_data(input int c0, input int c1, input int c2, input int c3);
      return {8'(8'h40 + c3), 8'(8'h30 + c2), 8'(8'h20 + c1), 8'(8'h10 + c0)};
   endfunction

   // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
   task automatic run_cycle(input logic r, input logic [3:0] rq, input logic f, input logic [31:0] d);
      logic [3:0] eg, ea;
      logic [7:0] ed;
      bit         acc;
      int         w;
      rst = r; req = rq; fifo_full = f; req_data = d;
      @(negedge clk);
      eg  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      acc = (m_owner >= 0) && rq[m_owner] && !f;
      ea  = acc ? eg : 4'b0000;
      ed  = (m_owner < 0) ? 8'h00 : d[m_owner*8 +: 8];
      obs_grant = grant; obs_ack = ack; obs_push = fifo_push; obs_data = fifo_data;
      check("model_grant", obs_grant, eg);
      check("model_ack",   obs_ack,   ea);
      check("model_push",  obs_push,  acc);
      check("model_data",  obs_data,  ed);
      if (r) begin
         m_owner = -1; m_ptr = 0; m_beats = 0;
      end else begin
         if (acc) m_beats++;
         if (m_owner < 0 || !rq[m_owner] || (acc && m_beats == MB)) begin
            w = rr_pick(rq, m_ptr);
            if (w >= 0) begin
               m_owner = w; m_ptr = (w + 1) % N; m_beats = 0;
            end else begin
               m_owner = -1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      run_cycle(1'b1, 4'b0000, 1'b0, 32'h0);
   endtask

   initial begin
      int cnt;
      int c0, c1, c2, c3;
      int per_owner [N];
      logic [3:0] rq;

      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
      tbl[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0};
      tbl[4]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
      tbl[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0};
      tbl[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hB1};
      tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'hB1};
      tbl[8]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[9]  = '{1'b0, 4'b1100, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'hD3};
      tbl[10] = '{1'b1, 4'b1100, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'hD3};
      tbl[11] = '{1'b0, 4'b1100, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[12] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC2};

      rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
      @(posedge clk); @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         run_cycle(tbl[i].rst, tbl[i].req, tbl[i].full, 32'hD3C2B1A0);
         check("vec_grant", obs_grant, tbl[i].g);
         check("vec_ack",   obs_ack,   tbl[i].a);
         check("vec_push",  obs_push,  tbl[i].p);
         check("vec_data",  obs_data,  tbl[i].d);
      end

      // Single requester, six beats: two back-to-back bursts with no bubble.
      do_reset();
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         rq = (cnt < 6) ? 4'b0001 : 4'b0000;
         run_cycle(1'b0, rq, 1'b0, mk_data(cnt, 0, 0, 0));
         glog[c] = obs_grant; plog[c] = obs_push;
         if (obs_push === 1'b1) begin
            check("single_data", obs_data, 8'(8'h10 + cnt));
            cnt++;
         end
      end
      check("single_beats", cnt, 6);
      check("single_idle0", plog[0], 1'b0);
      for (int c = 1; c <= 6; c++) begin
         check("single_push", plog[c], 1'b1);
         check("single_grant", glog[c], 4'b0001);
      end
      check("single_release", glog[8], 4'b0000);

      // Contention between requesters 0 and 1.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         run_cycle(1'b0, 4'b0011, 1'b0, mk_data(c, c, 0, 0));
         glog[c] = obs_grant;
      end
      check("cont_g1", glog[1], 4'b0001);
      check("cont_g4", glog[4], 4'b0001);
      check("cont_g5", glog[5], 4'b0010);
      check("cont_g8", glog[8], 4'b0010);
      check("cont_g9", glog[9], 4'b0001);

      // Fairness: all four requesting, each gets one full burst per round.
      do_reset();
      c0 = 0; c1 = 0; c2 = 0; c3 = 0;
      for (int i = 0; i < N; i++) per_owner[i] = 0;
      for (int c = 0; c <= 20; c++) begin
         run_cycle(1'b0, 4'b1111, 1'b0, mk_data(c0, c1, c2, c3));
         glog[c] = obs_grant;
         if (obs_ack[0] === 1'b1) c0++;
         if (obs_ack[1] === 1'b1) c1++;
         if (obs_ack[2] === 1'b1) c2++;
         if (obs_ack[3] === 1'b1) c3++;
         if (c <= 16)
            for (int i = 0; i < N; i++) if (obs_ack[i] === 1'b1) per_owner[i]++;
      end
      check("fair_g1",  glog[1],  4'b0001);
      check("fair_g5",  glog[5],  4'b0010);
      check("fair_g9",  glog[9],  4'b0100);
      check("fair_g13", glog[13], 4'b1000);
      check("fair_g17", glog[17], 4'b0001);
      for (int i = 0; i < N; i++) check("fair_beats", per_owner[i], MB);

      // Full stall for three cycles after beat 2.
      do_reset();
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         rq = (cnt < 4) ? 4'b0001 : 4'b0000;
         run_cycle(1'b0, rq, (c >= 3 && c <= 5), mk_data(cnt, 0, 0, 0));
         glog[c] = obs_grant; plog[c] = obs_push;
         if (obs_push === 1'b1) cnt++;
      end
      for (int c = 3; c <= 5; c++) begin
         check("stall_nopush", plog[c], 1'b0);
         check("stall_grant", glog[c], 4'b0001);
      end
      check("stall_beat3", plog[6], 1'b1);
      check("stall_beat4", plog[7], 1'b1);
      check("stall_total", cnt, 4);
      check("stall_release", glog[9], 4'b0000);

      // Early drop: requester 2 leaves after two beats, requester 3 takes over.
      do_reset();
      c2 = 0;
      for (int c = 0; c < 6; c++) begin
         rq = {1'b1, (c2 < 2), 2'b00};
         run_cycle(1'b0, rq, 1'b0, mk_data(0, 0, c2, 0));
         glog[c] = obs_grant; plog[c] = obs_push; dlog[c] = obs_data;
         if (obs_ack[2] === 1'b1) c2++;
      end
      check("drop_g1", glog[1], 4'b0100);
      check("drop_nopush", plog[3], 1'b0);
      check("drop_g4", glog[4], 4'b1000);
      check("drop_data", dlog[4], 8'h40);

      // Reset during beat 2 of requester 1; pointer restarts at 0.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         rq = (c < 2) ? 4'b0010 : 4'b0011;
         run_cycle((c == 2), rq, 1'b0, mk_data(0, c, 0, 0));
         glog[c] = obs_grant; plog[c] = obs_push;
      end
      check("rst_g2", glog[2], 4'b0010);
      check("rst_grant", glog[3], 4'b0000);
      check("rst_push", plog[3], 1'b0);
      check("rst_regrant", glog[4], 4'b0001);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         run_cycle(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
